// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared single-precision float definitions for the dsp datapath
//            (divider and multiplier): field widths, bias, divider state
//            encoding and field-extract helpers.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int WORD_W   = 1 + EXP_W + MANT_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_FIN    = 3'd4
    } fpdiv_state_t;

    function automatic logic fp_sign(input logic [WORD_W-1:0] f);
        return f[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [WORD_W-1:0] f);
        return f[WORD_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [WORD_W-1:0] f);
        return f[MANT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpdiv_if.sv
`default_nettype none
// ============================================================================
// Module   : fpdiv_if
// Brief    : Start/done request bus of the float divider. The master issues
//            operands with a one-cycle start; the slave returns the quotient
//            with done held high while it is valid.
// Revision : 1.0  initial release
// ============================================================================
interface fpdiv_if #(
    parameter int WORD_W = fp_pkg::WORD_W
);
    logic              start;
    logic [WORD_W-1:0] dataa;
    logic [WORD_W-1:0] datab;
    logic [WORD_W-1:0] result;
    logic              done;

    modport master (output start, dataa, datab, input  result, done);
    modport slave  (input  start, dataa, datab, output result, done);
endinterface
`default_nettype wire

// File: rtl/fpdiv_mant_div.sv
`default_nettype none
// ============================================================================
// Module   : fpdiv_mant_div
// Brief    : Sequential unsigned restoring divider, one quotient bit per
//            clock. load captures operands; N_ITER steps follow, and last
//            marks the cycle whose edge produces the final quotient bit.
// Revision : 1.0  initial release
// ============================================================================
module fpdiv_mant_div #(
    parameter int DVD_W  = 25,
    parameter int DVS_W  = 24,
    parameter int N_ITER = 25
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic [DVD_W-1:0]  dividend,
    input  wire logic [DVS_W-1:0]  divisor,
    output logic      [N_ITER-1:0] quotient,
    output logic      [DVD_W-1:0]  remainder,
    output logic                   busy,
    output logic                   last
);
    localparam int CNT_W = $clog2(N_ITER + 1);

    logic [DVD_W-1:0]  rem_q, rem_d;
    logic [DVS_W-1:0]  dvs_q, dvs_d;
    logic [N_ITER-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;

    logic [DVD_W-1:0]  w_dvs_ext;
    logic [DVD_W-1:0]  w_diff;
    logic              w_ge;

    assign w_dvs_ext = {{(DVD_W-DVS_W){1'b0}}, dvs_q};
    assign w_ge      = (rem_q >= w_dvs_ext);
    assign w_diff    = rem_q - w_dvs_ext;

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign last      = busy_q && (count_q == CNT_W'(N_ITER - 1));

    // One restoring step per cycle: conditional subtract, then shift left.
    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        count_d = count_q;
        busy_d  = busy_q;
        if (load) begin
            rem_d   = dividend;
            dvs_d   = divisor;
            quo_d   = '0;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            quo_d   = {quo_q[N_ITER-2:0], w_ge};
            rem_d   = w_ge ? {w_diff[DVD_W-2:0], 1'b0} : {rem_q[DVD_W-2:0], 1'b0};
            count_d = count_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers; reset aborts any step in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpdiv.sv
`default_nettype none
// ============================================================================
// Module   : fpdiv
// Brief    : Sequential IEEE-754 single-precision divider, result = a / b.
//            Handles sign, exponent, specials and normalisation around the
//            mantissa restoring divider. Denormals flush to zero.
//            Build option FPDIV_ROUND_EN: round-to-nearest-even (one extra
//            quotient bit, latency 28); otherwise truncation, latency 27.
// Revision : 1.0  initial release
// ============================================================================
module fpdiv #(
    parameter int MANT_W   = fp_pkg::MANT_W,
    parameter int EXP_W    = fp_pkg::EXP_W,
    parameter int EXP_BIAS = fp_pkg::EXP_BIAS
) (
    input  wire logic clk,
    input  wire logic reset,
    fpdiv_if.slave    bus
);
    import fp_pkg::*;

    localparam int WORD_W = 1 + EXP_W + MANT_W;
    localparam int EW     = EXP_W + 2;
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_INF  = EW'((1 << EXP_W) - 1);

`ifdef FPDIV_ROUND_EN
    localparam int N_ITER = MANT_W + 3;
    logic [MANT_W+1:0] w_rem;
    logic              w_guard;
    logic              w_sticky;
    logic [MANT_W:0]   w_mant_inc;
`else
    localparam int N_ITER = MANT_W + 2;
`endif

    fpdiv_state_t            state_q, state_d;
    logic                    sign_q, sign_d;
    logic [WORD_W-2:0]       opa_q, opa_d;
    logic [WORD_W-2:0]       opb_q, opb_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic [WORD_W-1:0]       result_q, result_d;
    logic                    done_q, done_d;

    logic [N_ITER-1:0]       w_quo;
    logic                    w_div_busy;
    logic                    w_div_last;
    logic                    w_top;
    logic [MANT_W-1:0]       w_mant;
    logic signed [EW-1:0]    w_e;
    logic [WORD_W-1:0]       w_norm_result;

    fpdiv_mant_div #(
        .DVD_W  (MANT_W + 2),
        .DVS_W  (MANT_W + 1),
        .N_ITER (N_ITER)
    ) u_mant_div (
        .clk       (clk),
        .reset     (reset),
        .load      (state_q == S_SETUP),
        .dividend  ({2'b01, fp_mant({1'b0, opa_q})}),
        .divisor   ({1'b1, fp_mant({1'b0, opb_q})}),
        .quotient  (w_quo),
`ifdef FPDIV_ROUND_EN
        .remainder (w_rem),
`else
        .remainder (),
`endif
        .busy      (w_div_busy),
        .last      (w_div_last)
    );

    // Normalise the quotient (in [0.5,2)), optionally round, then range-check.
    always_comb begin
        w_top = w_quo[N_ITER-1];
        if (w_top) begin
            w_mant = w_quo[N_ITER-2 -: MANT_W];
            w_e    = e_q;
        end else begin
            w_mant = w_quo[N_ITER-3 -: MANT_W];
            w_e    = e_q - EW'(1);
        end
`ifdef FPDIV_ROUND_EN
        // With the integer bit set there is one extra bit below the guard;
        // it belongs in the sticky, together with any nonzero remainder.
        w_guard    = w_top ? w_quo[1] : w_quo[0];
        w_sticky   = (w_rem != '0) | (w_top & w_quo[0]);
        w_mant_inc = {1'b0, w_mant} + {{MANT_W{1'b0}}, (w_guard & (w_sticky | w_mant[0]))};
        if (w_mant_inc[MANT_W]) begin
            w_mant = '0;
            w_e    = w_e + EW'(1);
        end else begin
            w_mant = w_mant_inc[MANT_W-1:0];
        end
`endif
        if (w_e <= E_ZERO) begin
            w_norm_result = {sign_q, {(WORD_W-1){1'b0}}};
        end else if (w_e >= E_INF) begin
            w_norm_result = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else begin
            w_norm_result = {sign_q, w_e[EXP_W-1:0], w_mant};
        end
    end

    // Control FSM: accept, exponent setup, wait for divider, normalise, hold.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        e_d      = e_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (bus.start) begin
                    sign_d = fp_sign(bus.dataa) ^ fp_sign(bus.datab);
                    opa_d  = bus.dataa[WORD_W-2:0];
                    opb_d  = bus.datab[WORD_W-2:0];
                    done_d = 1'b0;
                    // A zero exponent field means zero or denormal (flushed).
                    if (fp_exp(bus.datab) == '0) begin
                        result_d = {sign_d, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end else if (fp_exp(bus.dataa) == '0) begin
                        result_d = {sign_d, {(WORD_W-1){1'b0}}};
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                e_d     = EW'(fp_exp({1'b0, opa_q})) - EW'(fp_exp({1'b0, opb_q}))
                          + EW'(EXP_BIAS);
                state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (w_div_last || !w_div_busy) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                result_d = w_norm_result;
                done_d   = 1'b1;
                state_d  = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset clears any partial operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            e_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            e_q      <= e_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpdiv
// Brief    : Directed self-checking bench for fpdiv: arithmetic vectors,
//            specials, range limits, busy-time start, reset abort.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpdiv;

`ifdef FPDIV_ROUND_EN
    localparam int          LAT       = 28;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
    localparam int          LAT       = 27;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif
    localparam int MAX_WAIT = 60;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   lat      = 0;

    always #5 clk = ~clk;

    fpdiv_if u_if ();

    fpdiv u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic wait_done();
        while (u_if.done !== 1'b1 && lat < MAX_WAIT) tick();
    endtask

    // Issue one request, then check done timing and the quotient.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int exp_lat);
        @(posedge clk);
        #1;
        u_if.dataa = a;
        u_if.datab = b;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        lat = 0;
        if (exp_lat != 0) check_val({tag, "_busy"}, 32'(u_if.done), 32'd0);
        wait_done();
        check_val({tag, "_done"}, 32'(u_if.done), 32'd1);
        check_val({tag, "_lat"},  32'(lat),       32'(exp_lat));
        check_val({tag, "_res"},  u_if.result,    expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        u_if.start = 1'b0;
        u_if.dataa = '0;
        u_if.datab = '0;
        #12;
        check_val("rst_done", 32'(u_if.done), 32'd0);
        check_val("rst_res",  u_if.result,    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_op("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, LAT);
        run_op("div1_3",   32'h3F800000, 32'h40400000, ONE_THIRD,    LAT);
        run_op("neg8_h",   32'hC1000000, 32'h3F000000, 32'hC1800000, LAT);
        run_op("one_neg1", 32'h3F800000, 32'hBF800000, 32'hBF800000, LAT);
        run_op("div_by0",  32'h3F800000, 32'h00000000, 32'h7F800000, 0);
        run_op("zero_num", 32'h80000000, 32'h40000000, 32'h80000000, 0);
        run_op("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, LAT);
        run_op("unf",      32'h00800000, 32'h7F000000, 32'h00000000, LAT);

        // start pulsed while dividing must be ignored
        @(posedge clk);
        #1;
        u_if.dataa = 32'h40C00000;
        u_if.datab = 32'h40000000;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        lat = 0;
        repeat (10) tick();
        u_if.dataa = 32'h3F800000;
        u_if.datab = 32'hBF800000;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        wait_done();
        check_val("ign_done", 32'(u_if.done), 32'd1);
        check_val("ign_lat",  32'(lat),       32'(LAT));
        check_val("ign_res",  u_if.result,    32'h40400000);

        // reset ten cycles into an operation aborts it at once
        @(posedge clk);
        #1;
        u_if.dataa = 32'h3F800000;
        u_if.datab = 32'h40400000;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        lat = 0;
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        check_val("abort_done", 32'(u_if.done), 32'd0);
        check_val("abort_res",  u_if.result,    32'd0);
        @(posedge clk);
        #1;
        check_val("abort_hold", u_if.result,    32'd0);
        reset = 1'b1;

        run_op("after_rst", 32'h3F800000, 32'h40400000, ONE_THIRD, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpdiv.md
Name: fpdiv

Overview:
- Sequential IEEE-754 single-precision divider, result = dataa / datab.
- Inverse counterpart of the team's multi-step float multiplier.
- Sits in the dsp datapath next to the multiplier, for gain normalisation and filter-coefficient computation.
- Start/done handshake; mantissa quotient from a restoring shift-subtract loop, one quotient bit per clock.

Parameters:
- MANT_W, 23, stored mantissa width.
- EXP_W, 8, exponent field width.
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands sampled on the same edge.
- dataa  input  32  dividend (float).
- datab  input  32  divisor (float).
- result  output  32  quotient {sign, exp, mant}.
- done  output  1  high while result is valid.

Behaviour:
- Reset (reset=0, async): state=IDLE, done=0, result=0, counter=0.
- States: IDLE, SETUP, DIVIDE, NORM, FIN.
- start is honoured only in IDLE or FIN; it is ignored while busy.
- Accepting start clears done on the same edge.
- The sign is always dataa[31]^datab[31].
- Special cases, resolved on the accept edge (state->FIN, done=1 one cycle later):
  - datab[30:0]==0 gives inf: exp=0xFF, mant=0. This includes 0/0.
  - else dataa[30:0]==0 gives zero: exp=0, mant=0.
  - Denormal inputs are treated as zero (flush to zero). No NaN/inf input decoding.
- SETUP (1 cycle):
  - e = expa - expb + EXP_BIAS, held as a 10-bit signed value.
  - rem = {1'b0,1,manta} (25b); mb = {1,mantb}; q=0; count=0.
- DIVIDE (25 cycles), each cycle:
  - if rem>=mb: q={q,1}, rem=rem-mb; else q={q,0}.
  - Then rem<<=1 and count++.
  - Leave DIVIDE after count==24.
- NORM (1 cycle):
  - q[24]=1: mant=q[23:1], e unchanged.
  - q[24]=0: mant=q[22:0], e=e-1.
  - Rounding is truncation.
- Range checks on the final e:
  - e<=0 gives zero (exp=0, mant=0).
  - e>=255 gives inf (exp=0xFF, mant=0).
- NORM then moves to FIN: result and done=1 registered.
- Latency: start sampled at edge N gives done=1 after edge N+27 (normal path) or after edge N (special cases).
- FIN holds result and done until the next accepted start.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- Back-to-back: start while in FIN is accepted on that edge, so done drops for the new operation.

Optional Feature:
- Macro FPDIV_ROUND_EN.
- Defined:
  - round-to-nearest-even. DIVIDE runs 26 iterations, giving one guard bit; sticky = (final rem != 0).
  - Increment mant when guard & (sticky | lsb).
  - Mantissa carry-out sets mant=0 and e=e+1, followed by an overflow re-check.
  - Normal-path latency becomes 28.
- Undefined: truncation, latency 27.

Decomposition:
- Package fp_pkg:
  - EXP_BIAS, EXP_MAX=255, MANT_W, EXP_W;
  - the state encoding;
  - field-extract helpers (sign/exp/mant positions).
  - Shared with the multiplier.
- Sub-module fpdiv_mant_div:
  - parameterised sequential unsigned restoring divider (load, step count, quotient, remainder, busy);
  - the top handles the exponent, special cases and normalisation.

Test Plan:
- 6.0/2.0: 0x40C00000 / 0x40000000 -> result 0x40400000; done exactly 27 cycles after start (28 with FPDIV_ROUND_EN).
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA truncated; 0x3EAAAAAB with FPDIV_ROUND_EN.
- -8.0/0.5: 0xC1000000 / 0x3F000000 -> 0xC1800000. 0x3F800000/0xBF800000 -> 0xBF800000.
- Specials (done one cycle after start):
  - 0x3F800000 / 0x00000000 -> 0x7F800000;
  - 0x80000000 / 0x40000000 -> 0x80000000.
- Range:
  - 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow);
  - 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
- Control:
  - pulse start mid-DIVIDE -> ignored, original result unchanged;
  - assert reset at cycle 10 -> done=0, result=0 immediately;
  - next start -> correct result with full latency.
